// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_unit
// Purpose  : ID/EX hazard controller. It detects load-use hazards, inserts
//            LOAD_LAT bubbles for each one, flushes IF/ID on a taken branch
//            and freezes the whole pipeline while data memory is busy.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W   register-address width
//   LOAD_LAT bubbles inserted per load-use hazard (1..7)
//   CNT_W    width of the stall-cycle performance counter
// Build option
//   HDU_PERF_CNT_EN  when defined, a saturating stall-cycle counter is built.
//                    When undefined, stall_cycles_o is tied to 0.
// Ports
//   clk_i, rst_i     clock and synchronous active-high reset
//   EX_MemRead       the EX instruction is a load
//   EX_Rd_addr       destination register of the EX instruction
//   ID_Rs1/2_addr    source registers of the ID instruction
//   ID_use_rs1/2     the ID instruction actually reads rs1/rs2
//   branch_taken_i   the branch in ID resolved taken
//   mem_busy_i       data memory is not ready
//   noop             insert a bubble into ID/EX
//   stall            hold IF/ID
//   PCWrite          PC write-enable
//   flush_o          clear IF/ID
//   freeze_o         hold all pipeline registers
//   stall_cycles_o   stall-cycle performance counter
// ============================================================================
module hazard_ctrl_unit #(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              EX_MemRead,
  input  logic [ADDR_W-1:0] EX_Rd_addr,
  input  logic [ADDR_W-1:0] ID_Rs1_addr,
  input  logic [ADDR_W-1:0] ID_Rs2_addr,
  input  logic              ID_use_rs1,
  input  logic              ID_use_rs2,
  input  logic              branch_taken_i,
  input  logic              mem_busy_i,
  output logic              noop,
  output logic              stall,
  output logic              PCWrite,
  output logic              flush_o,
  output logic              freeze_o,
  output logic [CNT_W-1:0]  stall_cycles_o
);

  // Reject out-of-range latencies at elaboration time; bcnt is 3 bits wide.
  generate
    if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_load_lat
      $error("hazard_ctrl_unit: LOAD_LAT must be in 1..7");
    end
  endgenerate

  // The detecting cycle is itself the first bubble, so the BUBBLE state
  // covers the remaining LOAD_LAT-1 cycles (bcnt counts down to 0).
  localparam bit          C_MULTI     = (LOAD_LAT > 1);
  localparam int          C_INIT_INT  = (LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0;
  localparam logic [2:0]  C_BCNT_INIT = 3'(C_INIT_INT);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] bcnt_q,  bcnt_d;
  logic       ld_hz;

  // A hazard exists only when ID really reads the register the load writes.
  // x0 is hard-wired to zero and can never be a real dependency.
  assign ld_hz = EX_MemRead
               & (EX_Rd_addr != '0)
               & ((ID_use_rs1 & (EX_Rd_addr == ID_Rs1_addr))
                | (ID_use_rs2 & (EX_Rd_addr == ID_Rs2_addr)));

  // --------------------------------------------------------------------------
  // Next-state logic. A busy memory freezes the FSM and the bubble count.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    if (!mem_busy_i) begin
      case (state_q)
        ST_RUN: begin
          // With LOAD_LAT=1 the single bubble removes the load from EX,
          // which clears ld_hz by itself, so no extra state is needed.
          if (ld_hz && C_MULTI) begin
            state_d = ST_BUBBLE;
            bcnt_d  = C_BCNT_INIT;
          end
        end
        ST_BUBBLE: begin
          if (bcnt_q == 3'd0) begin
            state_d = ST_RUN;
          end else begin
            bcnt_d = bcnt_q - 3'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          bcnt_d  = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      bcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode. Outputs are combinational so the first bubble appears in
  // the detection cycle. The stall wins over a simultaneous taken branch
  // because the branch operands are not valid yet; the branch is simply
  // re-evaluated once the stall has drained.
  // --------------------------------------------------------------------------
  always_comb begin
    noop     = 1'b0;
    stall    = 1'b0;
    PCWrite  = 1'b1;
    flush_o  = 1'b0;
    freeze_o = 1'b0;
    if (rst_i) begin
      // idle outputs while in reset
    end else if (mem_busy_i) begin
      freeze_o = 1'b1;
      stall    = 1'b1;
      PCWrite  = 1'b0;
    end else if (state_q == ST_BUBBLE || ld_hz) begin
      noop    = 1'b1;
      stall   = 1'b1;
      PCWrite = 1'b0;
    end else if (branch_taken_i) begin
      flush_o = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Optional stall-cycle counter (saturating).
  // --------------------------------------------------------------------------
`ifdef HDU_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stall_cycles_o = cnt_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl_unit
// Purpose  : Self-checking bench for hazard_ctrl_unit. Two instances share
//            one input set: u_lat1 (LOAD_LAT=1) and u_lat3 (LOAD_LAT=3,
//            CNT_W=4). Directed vectors push hand-computed expectations into
//            a queue; a monitor on the falling edge pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_unit;

`ifdef HDU_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {noop, stall, PCWrite, flush_o, freeze_o}
  localparam logic [4:0] IDLE   = 5'b00100;
  localparam logic [4:0] BUBL   = 5'b11000;
  localparam logic [4:0] FRZ    = 5'b01001;
  localparam logic [4:0] FLUSH  = 5'b00110;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       EX_MemRead;
  logic [4:0] EX_Rd_addr, ID_Rs1_addr, ID_Rs2_addr;
  logic       ID_use_rs1, ID_use_rs2, branch_taken_i, mem_busy_i;

  logic        noop1, stall1, pcw1, flush1, frz1;
  logic [15:0] cnt1;
  logic        noop3, stall3, pcw3, flush3, frz3;
  logic [3:0]  cnt3;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.ADDR_W(5), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
    .clk_i(clk), .rst_i(rst_i), .EX_MemRead(EX_MemRead), .EX_Rd_addr(EX_Rd_addr),
    .ID_Rs1_addr(ID_Rs1_addr), .ID_Rs2_addr(ID_Rs2_addr),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .branch_taken_i(branch_taken_i), .mem_busy_i(mem_busy_i),
    .noop(noop1), .stall(stall1), .PCWrite(pcw1), .flush_o(flush1),
    .freeze_o(frz1), .stall_cycles_o(cnt1)
  );

  hazard_ctrl_unit #(.ADDR_W(5), .LOAD_LAT(3), .CNT_W(4)) u_lat3 (
    .clk_i(clk), .rst_i(rst_i), .EX_MemRead(EX_MemRead), .EX_Rd_addr(EX_Rd_addr),
    .ID_Rs1_addr(ID_Rs1_addr), .ID_Rs2_addr(ID_Rs2_addr),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .branch_taken_i(branch_taken_i), .mem_busy_i(mem_busy_i),
    .noop(noop3), .stall(stall3), .PCWrite(pcw3), .flush_o(flush3),
    .freeze_o(frz3), .stall_cycles_o(cnt3)
  );

  typedef struct {
    int         sel;      // 1 = u_lat1, 3 = u_lat3
    string      name;
    bit         is_cnt;   // compare stall_cycles_o of u_lat3 instead
    logic [4:0] outs;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Monitor: pops every expectation pushed for the current cycle.
  initial begin
    exp_t       e;
    logic [4:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (e.is_cnt) begin
          if (int'(cnt3) != e.cnt) begin
            n_errors++;
            $display("FAIL %s: stall_cycles_o=%0d expected %0d", e.name, cnt3, e.cnt);
          end
        end else begin
          act = (e.sel == 1) ? {noop1, stall1, pcw1, flush1, frz1}
                             : {noop3, stall3, pcw3, flush3, frz3};
          if (act !== e.outs) begin
            n_errors++;
            $display("FAIL %s (lat%0d): {noop,stall,PCWrite,flush,freeze}=%b expected %b",
                     e.name, e.sel, act, e.outs);
          end
        end
      end
    end
  end

  // Apply one cycle of inputs shortly after the rising edge.
  task automatic drv(input logic r, input logic md, input logic [4:0] rd,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input logic u1, input logic u2, input logic br, input logic bz);
    @(posedge clk);
    #1;
    rst_i = r; EX_MemRead = md; EX_Rd_addr = rd;
    ID_Rs1_addr = r1; ID_Rs2_addr = r2;
    ID_use_rs1 = u1; ID_use_rs2 = u2;
    branch_taken_i = br; mem_busy_i = bz;
  endtask

  task automatic idle_in();
    drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic exp_o(input int sel, input string nm, input logic [4:0] o);
    exp_t e;
    e.sel = sel; e.name = nm; e.is_cnt = 1'b0; e.outs = o; e.cnt = 0;
    sb.push_back(e);
  endtask

  task automatic exp_c(input string nm, input int c);
    exp_t e;
    e.sel = 3; e.name = nm; e.is_cnt = 1'b1; e.outs = '0; e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    drv(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; EX_MemRead = 1'b0; EX_Rd_addr = '0; ID_Rs1_addr = '0;
    ID_Rs2_addr = '0; ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0;
    branch_taken_i = 1'b0; mem_busy_i = 1'b0;

    // Reset held two cycles with a would-be hazard present.
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_o(1, "rst_outs", IDLE);
      exp_o(3, "rst_outs", IDLE);
    end
    exp_c("rst_cnt", 0);
    idle_in(); exp_o(1, "post_rst", IDLE); exp_o(3, "post_rst", IDLE);

    // LOAD_LAT=1: rs2 hazard gives exactly one bubble.
    drv(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_o(1, "l1_rs2_hz", BUBL);
    idle_in(); exp_o(1, "l1_after", IDLE);
    // rs2 match but not read -> ignored.
    drv(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_o(1, "l1_no_use", IDLE);
    // Rd = x0 -> never a hazard.
    drv(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_o(1, "l1_rd_x0", IDLE);
    // Not a load -> no hazard.
    drv(1'b0, 1'b0, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_o(1, "l1_not_load", IDLE);

    // LOAD_LAT=1: hazard and taken branch together, then branch alone.
    drv(1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_o(1, "l1_hz_br", BUBL);
    drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_o(1, "l1_br_retry", FLUSH);
    // Busy beats everything.
    drv(1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_o(1, "l1_busy", FRZ);
    idle_in(); exp_o(1, "l1_after_busy", IDLE);

    do_reset();
    idle_in(); exp_o(3, "l3_idle", IDLE);

    // LOAD_LAT=3: rs1 hazard gives exactly 3 bubbles.
    drv(1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_o(3, "l3_bub1", BUBL);
    idle_in(); exp_o(3, "l3_bub2", BUBL);
    idle_in(); exp_o(3, "l3_bub3", BUBL);
    idle_in(); exp_o(3, "l3_done", IDLE);

    // LOAD_LAT=3: busy for 2 cycles during the 2nd bubble.
    drv(1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_o(3, "l3b_bub1", BUBL);
    drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_o(3, "l3b_frz1", FRZ);
    drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_o(3, "l3b_frz2", FRZ);
    idle_in(); exp_o(3, "l3b_bub2", BUBL);
    idle_in(); exp_o(3, "l3b_bub3", BUBL);
    idle_in(); exp_o(3, "l3b_done", IDLE);
    // Plain taken branch in RUN.
    drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_o(3, "l3_branch", FLUSH);

    // Reset mid-stall abandons remaining bubbles.
    drv(1'b0, 1'b1, 5'd3, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_o(3, "l3r_bub1", BUBL);
    do_reset(); exp_o(3, "l3r_in_rst", IDLE);
    idle_in(); exp_o(3, "l3r_after", IDLE);

    // Counter: 20 frozen (stall=1) cycles on the 4-bit counter.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      exp_o(3, "sat_frz", FRZ);
      exp_c("sat_cnt", PERF ? ((i > 15) ? 15 : i) : 0);
    end
    do_reset(); exp_c("sat_final", PERF ? 15 : 0);
    idle_in();  exp_c("cnt_cleared", 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
